// File: rtl/clock_setter_pkg.sv
// Shared types, BCD limits and increment helpers for the clock setter.
package clock_setter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EDIT_HOUR,
    EDIT_MIN,
    COMMIT
  } state_t;

  localparam logic [1:0] HOUR_TENS_MAX        = 2'd2;
  localparam logic [3:0] HOUR_UNITS_MAX_AT_20 = 4'd3;
  localparam logic [3:0] MIN_TENS_MAX         = 4'd5;
  localparam logic [3:0] BCD_MAX              = 4'd9;

  // HH:MM in BCD, laid out to match the output port order
  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } hhmm_t;

  // Hours count 00..23; minutes are left untouched
  function automatic hhmm_t inc_hour(input hhmm_t v);
    hhmm_t r;
    r = v;
    if (v.h1 == HOUR_TENS_MAX && v.h0 == HOUR_UNITS_MAX_AT_20) begin
      r.h1 = '0;
      r.h0 = '0;
    end else if (v.h0 == BCD_MAX) begin
      r.h0 = '0;
      r.h1 = v.h1 + 2'd1;
    end else begin
      r.h0 = v.h0 + 4'd1;
    end
    return r;
  endfunction

  // Minutes count 00..59 and wrap without carrying into hours
  function automatic hhmm_t inc_min(input hhmm_t v);
    hhmm_t r;
    r = v;
    if (v.m0 == BCD_MAX) begin
      r.m0 = '0;
      r.m1 = (v.m1 == MIN_TENS_MAX) ? 4'd0 : v.m1 + 4'd1;
    end else begin
      r.m0 = v.m0 + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/clock_setter_btn_debounce.sv
// Per-button synchronizer + debouncer; emits a one-cycle pulse on accepted press.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronize, then flip the debounced level once the new value has persisted
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clock_setter.sv
// Button front end for the BCD alarm clock: edits HH:MM and issues load strobes.
module clock_setter
  import clock_setter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_set_time,
  input  logic       btn_set_alarm,
  input  logic       btn_next,
  input  logic       btn_inc,
  output logic [1:0] Hour_in1,
  output logic [3:0] Hour_in0,
  output logic [3:0] Minute_in1,
  output logic [3:0] Minute_in0,
  output logic       Load_time,
  output logic       Load_alarm,
  output logic       Al_On,
  output logic       Stop_alarm,
  output logic       editing
);

  logic p_set_time;
  logic p_set_alarm;
  logic p_next;
  logic p_inc;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set_time (
    .clk(clk), .reset(reset), .raw(btn_set_time), .press(p_set_time)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set_alarm (
    .clk(clk), .reset(reset), .raw(btn_set_alarm), .press(p_set_alarm)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .reset(reset), .raw(btn_next), .press(p_next)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .reset(reset), .raw(btn_inc), .press(p_inc)
  );

  state_t state;
  logic   target;
  hhmm_t  edit;
  hhmm_t  time_sh;
  hhmm_t  alarm_sh;

  assign Hour_in1   = edit.h1;
  assign Hour_in0   = edit.h0;
  assign Minute_in1 = edit.m1;
  assign Minute_in0 = edit.m0;

  // Edit FSM; strobes are registered so they coincide with the COMMIT state
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      target     <= 1'b0;
      edit       <= '0;
      time_sh    <= '0;
      alarm_sh   <= '0;
      Load_time  <= 1'b0;
      Load_alarm <= 1'b0;
      Al_On      <= 1'b0;
      Stop_alarm <= 1'b0;
      editing    <= 1'b0;
    end else begin
      Load_time  <= 1'b0;
      Load_alarm <= 1'b0;
      Stop_alarm <= 1'b0;
      case (state)
        IDLE: begin
          if (p_set_time) begin
            edit    <= time_sh;
            target  <= 1'b0;
            state   <= EDIT_HOUR;
            editing <= 1'b1;
          end else if (p_set_alarm) begin
            edit    <= alarm_sh;
            target  <= 1'b1;
            state   <= EDIT_HOUR;
            editing <= 1'b1;
          end else if (p_next) begin
            Al_On <= ~Al_On;
          end else if (p_inc) begin
            Stop_alarm <= 1'b1;
          end
        end
        EDIT_HOUR: begin
          if (p_next) begin
            state <= EDIT_MIN;
          end else if (p_inc) begin
            edit <= inc_hour(edit);
          end
        end
        EDIT_MIN: begin
          if (p_next) begin
            state      <= COMMIT;
            editing    <= 1'b0;
            Load_time  <= ~target;
            Load_alarm <= target;
          end else if (p_inc) begin
            edit <= inc_min(edit);
          end
        end
        COMMIT: begin
          if (target) begin
            alarm_sh <= edit;
          end else begin
            time_sh <= edit;
          end
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          editing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_setter.sv
// Directed bench for clock_setter.
module tb_clock_setter;

  localparam int unsigned DEB = 4;
  localparam int ST = 0;
  localparam int SA = 1;
  localparam int NX = 2;
  localparam int IN = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic [1:0] Hour_in1;
  logic [3:0] Hour_in0;
  logic [3:0] Minute_in1;
  logic [3:0] Minute_in0;
  logic       Load_time;
  logic       Load_alarm;
  logic       Al_On;
  logic       Stop_alarm;
  logic       editing;

  clock_setter #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk),
    .reset(reset),
    .btn_set_time(btn[ST]),
    .btn_set_alarm(btn[SA]),
    .btn_next(btn[NX]),
    .btn_inc(btn[IN]),
    .Hour_in1(Hour_in1),
    .Hour_in0(Hour_in0),
    .Minute_in1(Minute_in1),
    .Minute_in0(Minute_in0),
    .Load_time(Load_time),
    .Load_alarm(Load_alarm),
    .Al_On(Al_On),
    .Stop_alarm(Stop_alarm),
    .editing(editing)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          lt_cnt = 0;
  int          la_cnt = 0;
  int          sa_cnt = 0;
  int          excl_err = 0;
  logic [13:0] lt_val = '0;
  logic [13:0] la_val = '0;

  // Strobe monitor on the falling edge
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (Load_time === 1'b1) begin
        lt_cnt++;
        lt_val = {Hour_in1, Hour_in0, Minute_in1, Minute_in0};
      end
      if (Load_alarm === 1'b1) begin
        la_cnt++;
        la_val = {Hour_in1, Hour_in0, Minute_in1, Minute_in0};
      end
      if (Stop_alarm === 1'b1) sa_cnt++;
      if (Load_time === 1'b1 && Load_alarm === 1'b1) excl_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hm(input int h1, input int h0, input int m1, input int m0);
    logic [13:0] v;
    v = {h1[1:0], h0[3:0], m1[3:0], m0[3:0]};
    return 32'(v);
  endfunction

  function automatic logic [31:0] disp();
    return 32'({Hour_in1, Hour_in0, Minute_in1, Minute_in0});
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the selected buttons long enough to debounce, then release fully
  task automatic press(input logic [3:0] mask);
    btn = mask;
    tick(DEB + 4);
    btn = '0;
    tick(DEB + 4);
  endtask

  task automatic press_n(input int b, input int n);
    logic [3:0] m;
    m = '0;
    m[b] = 1'b1;
    for (int i = 0; i < n; i++) press(m);
  endtask

  int k;
  logic prev;
  int lt0;
  int la0;

  initial begin
    btn   = '0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);

    // reset state
    check("rst_disp", disp(), hm(0, 0, 0, 0));
    check("rst_ctrl", 32'({Load_time, Load_alarm, Al_On, Stop_alarm, editing}), 32'd0);

    // plain time commit of 00:00
    press_n(ST, 1);
    check("edit_on", 32'(editing), 32'd1);
    press_n(NX, 2);
    check("commit0_lt", 32'(lt_cnt), 32'd1);
    check("commit0_la", 32'(la_cnt), 32'd0);
    check("commit0_val", 32'(lt_val), hm(0, 0, 0, 0));
    check("edit_off", 32'(editing), 32'd0);

    // hour and minute wrap
    press_n(ST, 1);
    press_n(IN, 23);
    check("hour23", disp(), hm(2, 3, 0, 0));
    press_n(IN, 1);
    check("hour_wrap", disp(), hm(0, 0, 0, 0));
    press_n(NX, 1);
    press_n(IN, 59);
    check("min59", disp(), hm(0, 0, 5, 9));
    press_n(IN, 1);
    check("min_wrap", disp(), hm(0, 0, 0, 0));
    press_n(NX, 1);
    check("commit1_lt", 32'(lt_cnt), 32'd2);

    // alarm 23:59
    press_n(SA, 1);
    press_n(IN, 23);
    press_n(NX, 1);
    press_n(IN, 59);
    press_n(NX, 1);
    check("alarm_la", 32'(la_cnt), 32'd1);
    check("alarm_val", 32'(la_val), hm(2, 3, 5, 9));
    check("alarm_lt", 32'(lt_cnt), 32'd2);
    check("hold_after", disp(), hm(2, 3, 5, 9));
    press_n(SA, 1);
    check("alarm_reload", disp(), hm(2, 3, 5, 9));
    press_n(NX, 2);
    check("alarm_la2", 32'(la_cnt), 32'd2);

    // bounce on next, then steady high: one Al_On toggle at fixed latency
    for (int i = 0; i < 10; i++) begin
      btn[NX] = ~btn[NX];
      tick(1);
    end
    btn[NX] = 1'b1;
    prev = Al_On;
    k = -1;
    for (int c = 1; c <= 40; c++) begin
      tick(1);
      if (Al_On !== prev) begin
        k = c;
        break;
      end
    end
    check("bounce_latency", 32'(k), 32'(DEB + 4));
    tick(DEB + 4);
    btn = '0;
    tick(DEB + 6);
    check("bounce_alon", 32'(Al_On), 32'd1);

    // short glitch is rejected
    btn[NX] = 1'b1;
    tick(DEB - 1);
    btn[NX] = 1'b0;
    tick(DEB + 8);
    check("glitch", 32'(Al_On), 32'd1);

    press_n(NX, 1);
    check("alon_off", 32'(Al_On), 32'd0);
    press_n(IN, 1);
    check("stop_alarm", 32'(sa_cnt), 32'd1);

    // simultaneous set_time + set_alarm enters time edit (time shadow 00:00)
    press(4'b0011);
    check("prio_edit", 32'(editing), 32'd1);
    check("prio_val", disp(), hm(0, 0, 0, 0));
    press_n(NX, 1);
    press_n(IN, 1);
    check("pre_reset", disp(), hm(0, 0, 0, 1));

    // reset mid-edit
    lt0 = lt_cnt;
    la0 = la_cnt;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    check("mid_rst_disp", disp(), hm(0, 0, 0, 0));
    check("mid_rst_ctrl", 32'({Load_time, Load_alarm, Al_On, Stop_alarm, editing}), 32'd0);
    check("mid_rst_nolt", 32'(lt_cnt), 32'(lt0));
    check("mid_rst_nola", 32'(la_cnt), 32'(la0));
    press_n(SA, 1);
    check("alarm_sh_clr", disp(), hm(0, 0, 0, 0));
    press_n(NX, 2);
    press_n(ST, 1);
    check("time_sh_clr", disp(), hm(0, 0, 0, 0));
    press_n(NX, 2);
    check("final_lt", 32'(lt_cnt), 32'(lt0 + 1));
    check("final_la", 32'(la_cnt), 32'(la0 + 1));
    check("strobe_excl", 32'(excl_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
